// File: rtl/fractal_sync_1d_rf_ctrl.sv
`timescale 1ns/1ps
// Fractal-sync 1D remote-RF request controller: one IDLE/CHECK/RESP engine per port.
// Each engine buffers one request, checks it against the remote RF once, and reports DONE/ERR.

module fractal_sync_1d_rf_ctrl_port #(
    parameter int unsigned LEVEL_WIDTH = 1,
    parameter int unsigned ID_WIDTH    = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [LEVEL_WIDTH-1:0] req_level_i,
    input  logic [ID_WIDTH-1:0]    req_id_i,
    output logic [LEVEL_WIDTH-1:0] rf_level_o,
    output logic [ID_WIDTH-1:0]    rf_id_o,
    output logic                   rf_check_o,
    input  logic                   rf_present_i,
    input  logic                   rf_sig_err_i,
    input  logic                   rf_bypass_i,
    input  logic                   rf_ignore_i,
    output logic                   resp_valid_o,
    input  logic                   resp_ready_i,
    output logic                   resp_err_o,
    output logic [LEVEL_WIDTH-1:0] resp_level_o,
    output logic [ID_WIDTH-1:0]    resp_id_o
);
    typedef struct packed {
        logic [LEVEL_WIDTH-1:0] level;
        logic [ID_WIDTH-1:0]    id;
    } sync_req_t;

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_e;

    state_e    state_q, state_d;
    sync_req_t buf_q, buf_d;
    logic      err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    // The RF answer is only valid during CHECK and the RF commits its update at the
    // end of that cycle, so CHECK always leaves after one cycle.
    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        err_d        = err_q;
        req_ready_o  = 1'b0;
        rf_check_o   = 1'b0;
        resp_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    buf_d.level = req_level_i;
                    buf_d.id    = req_id_i;
                    err_d       = 1'b0;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                rf_check_o = 1'b1;
                if (rf_sig_err_i) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (rf_ignore_i) begin
                    state_d = IDLE;
                end else if (rf_bypass_i || rf_present_i) begin
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rf_level_o   = buf_q.level;
    assign rf_id_o      = buf_q.id;
    assign resp_err_o   = err_q;
    assign resp_level_o = buf_q.level;
    assign resp_id_o    = buf_q.id;

`ifndef SYNTHESIS
    a_check_single : assert property (@(posedge clk_i) disable iff (!rst_ni)
        rf_check_o |=> !rf_check_o);
    a_resp_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        resp_valid_o && !resp_ready_i |=> resp_valid_o && $stable({resp_err_o, resp_level_o, resp_id_o}));
`endif

endmodule

module fractal_sync_1d_rf_ctrl #(
    parameter int unsigned LEVEL_WIDTH = 1,
    parameter int unsigned ID_WIDTH    = 1,
    parameter int unsigned N_PORTS     = 2
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_PORTS-1:0]                  req_valid_i,
    output logic [N_PORTS-1:0]                  req_ready_o,
    input  logic [N_PORTS-1:0][LEVEL_WIDTH-1:0] req_level_i,
    input  logic [N_PORTS-1:0][ID_WIDTH-1:0]    req_id_i,
    output logic [N_PORTS-1:0][LEVEL_WIDTH-1:0] rf_level_o,
    output logic [N_PORTS-1:0][ID_WIDTH-1:0]    rf_id_o,
    output logic [N_PORTS-1:0]                  rf_check_o,
    input  logic [N_PORTS-1:0]                  rf_present_i,
    input  logic [N_PORTS-1:0]                  rf_sig_err_i,
    input  logic [N_PORTS-1:0]                  rf_bypass_i,
    input  logic [N_PORTS-1:0]                  rf_ignore_i,
    output logic [N_PORTS-1:0]                  resp_valid_o,
    input  logic [N_PORTS-1:0]                  resp_ready_i,
    output logic [N_PORTS-1:0]                  resp_err_o,
    output logic [N_PORTS-1:0][LEVEL_WIDTH-1:0] resp_level_o,
    output logic [N_PORTS-1:0][ID_WIDTH-1:0]    resp_id_o
);
    // Ports are independent; same-cycle pairing is arbitrated inside the RF.
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
        fractal_sync_1d_rf_ctrl_port #(
            .LEVEL_WIDTH (LEVEL_WIDTH),
            .ID_WIDTH    (ID_WIDTH)
        ) i_port (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .req_valid_i  (req_valid_i[gi]),
            .req_ready_o  (req_ready_o[gi]),
            .req_level_i  (req_level_i[gi]),
            .req_id_i     (req_id_i[gi]),
            .rf_level_o   (rf_level_o[gi]),
            .rf_id_o      (rf_id_o[gi]),
            .rf_check_o   (rf_check_o[gi]),
            .rf_present_i (rf_present_i[gi]),
            .rf_sig_err_i (rf_sig_err_i[gi]),
            .rf_bypass_i  (rf_bypass_i[gi]),
            .rf_ignore_i  (rf_ignore_i[gi]),
            .resp_valid_o (resp_valid_o[gi]),
            .resp_ready_i (resp_ready_i[gi]),
            .resp_err_o   (resp_err_o[gi]),
            .resp_level_o (resp_level_o[gi]),
            .resp_id_o    (resp_id_o[gi])
        );
    end

endmodule

// File: tb/tb_fractal_sync_1d_rf_ctrl.sv
`timescale 1ns/1ps
// Directed + random bench for fractal_sync_1d_rf_ctrl with a small remote-RF model attached.

module tb_fractal_sync_1d_rf_ctrl;
    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      req_valid, req_ready;
    logic [1:0][1:0] req_level, req_id;
    logic [1:0][1:0] rf_level, rf_id;
    logic [1:0]      rf_check, rf_present, rf_sig_err, rf_bypass, rf_ignore;
    logic [1:0]      resp_valid, resp_ready, resp_err;
    logic [1:0][1:0] resp_level, resp_id;

    logic [1:0]      force_err;
    logic [15:0]     rec;
    logic            same;
    int              pairs = 0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fractal_sync_1d_rf_ctrl #(.LEVEL_WIDTH(2), .ID_WIDTH(2), .N_PORTS(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_level_i(req_level), .req_id_i(req_id),
        .rf_level_o(rf_level), .rf_id_o(rf_id), .rf_check_o(rf_check),
        .rf_present_i(rf_present), .rf_sig_err_i(rf_sig_err),
        .rf_bypass_i(rf_bypass), .rf_ignore_i(rf_ignore),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_err_o(resp_err),
        .resp_level_o(resp_level), .resp_id_o(resp_id)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Remote RF: one record bit per signature; same-cycle pair -> port0 bypass, port1 ignore.
    always_comb begin
        rf_present = '0;
        rf_sig_err = '0;
        same = rf_check[0] && rf_check[1] && (rf_level[0] == rf_level[1]) && (rf_id[0] == rf_id[1]);
        rf_bypass = {1'b0, same};
        rf_ignore = {same, 1'b0};
        for (int p = 0; p < 2; p++) begin
            rf_present[p] = rf_check[p] && rec[{rf_level[p], rf_id[p]}];
            rf_sig_err[p] = rf_check[p] && force_err[p];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rec <= '0;
        else if (!same) begin
            for (int p = 0; p < 2; p++)
                if (rf_check[p] && !force_err[p])
                    rec[{rf_level[p], rf_id[p]}] <= !rec[{rf_level[p], rf_id[p]}];
        end
    end

    always @(posedge clk)
        pairs <= pairs + (same ? 1 : $countones(rf_present & ~rf_sig_err));

    // Output monitor: check-strobe and handshake counters, response stability.
    int         n_chk [2] = '{0, 0};
    int         n_done = 0;
    int         n_err  = 0;
    logic [1:0] hold = '0;
    logic [1:0][4:0] last;

    always @(negedge clk) begin
        if (!rst_n) hold <= '0;
        else begin
            for (int p = 0; p < 2; p++) begin
                if (hold[p])
                    chk("stable", 32'({resp_valid[p], resp_err[p], resp_level[p], resp_id[p]}),
                        32'({1'b1, last[p]}));
                if (rf_check[p]) n_chk[p] <= n_chk[p] + 1;
            end
            n_done <= n_done + $countones(resp_valid & resp_ready & ~resp_err);
            n_err  <= n_err + $countones(resp_valid & resp_ready & resp_err);
            hold   <= resp_valid & ~resp_ready;
            for (int p = 0; p < 2; p++) last[p] <= {resp_err[p], resp_level[p], resp_id[p]};
        end
    end

    task automatic send(input int p, input logic [1:0] l, input logic [1:0] i);
        req_valid[p] = 1'b1;
        req_level[p] = l;
        req_id[p]    = i;
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic ack(input int p);
        resp_ready[p] = 1'b1;
        @(posedge clk); #1;
        resp_ready[p] = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int acc [2];
        int issued, cyc, s0, s1, sd, se, sp, ns;
        logic [1:0] hs;

        rst_n = 1'b0; req_valid = '0; req_level = '0; req_id = '0;
        resp_ready = '0; force_err = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rdy", 32'(req_ready), 32'h3);
        chk("rst_chk", 32'(rf_check), 32'h0);
        chk("rst_vld", 32'(resp_valid), 32'h0);
        chk("rst_err", 32'(resp_err), 32'h0);
        chk("rst_pay", 32'({rf_level, rf_id, resp_level, resp_id}), 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: first arrival on port0, partner on port1 four cycles later
        send(0, 2'd1, 2'd2);
        @(negedge clk);
        chk("s1_p0_check", 32'(rf_check), 32'h1);
        chk("s1_p0_rf", 32'({rf_level[0], rf_id[0]}), 32'h6);
        @(posedge clk); #1; @(negedge clk);
        chk("s1_p0_silent", 32'({resp_valid, rf_check, req_ready[0]}), 32'h1);
        repeat (2) @(posedge clk); #1;
        send(1, 2'd1, 2'd2);
        @(negedge clk);
        chk("s1_p1_check", 32'(rf_check), 32'h2);
        chk("s1_p1_lat1", 32'(resp_valid), 32'h0);
        @(posedge clk); #1; @(negedge clk);
        chk("s1_p1_vld", 32'(resp_valid), 32'h2);
        chk("s1_p1_pay", 32'({resp_err[1], resp_level[1], resp_id[1]}), 32'h06);
        ack(1);
        chk("s1_p1_idle", 32'({resp_valid[1], req_ready[1]}), 32'h1);
        @(posedge clk); #1;
        chk("s1_nchk0", 32'(n_chk[0]), 32'd1);
        chk("s1_nchk1", 32'(n_chk[1]), 32'd1);

        // 2: same-cycle pair, port0 bypass wins, port1 ignored
        req_valid = 2'b11; req_level = {2'd1, 2'd1}; req_id = {2'd3, 2'd3};
        @(posedge clk); #1; req_valid = '0;
        @(negedge clk);
        chk("s2_check", 32'(rf_check), 32'h3);
        @(posedge clk); #1; @(negedge clk);
        chk("s2_vld", 32'(resp_valid), 32'h1);
        chk("s2_rdy1", 32'(req_ready[1]), 32'h1);
        chk("s2_pay0", 32'({resp_err[0], resp_level[0], resp_id[0]}), 32'h07);
        ack(0);
        chk("s2_idle", 32'({resp_valid, req_ready}), 32'h3);

        // 3: sig_err together with present -> ERR
        @(posedge clk); #1;
        send(1, 2'd2, 2'd1);
        @(posedge clk); #1;
        force_err[0] = 1'b1;
        send(0, 2'd2, 2'd1);
        @(negedge clk);
        chk("s3_check", 32'(rf_check), 32'h1);
        @(posedge clk); #1; @(negedge clk);
        chk("s3_vld", 32'(resp_valid), 32'h1);
        chk("s3_pay", 32'({resp_err[0], resp_level[0], resp_id[0]}), 32'h19);
        ack(0);
        force_err = '0;

        // 4: DONE held five cycles under back-pressure
        @(posedge clk); #1;
        send(1, 2'd3, 2'd0);
        @(posedge clk); #1;
        send(0, 2'd3, 2'd0);
        @(posedge clk); #1;
        ns = n_chk[0] + n_chk[1];
        send_stray: begin
            req_valid[0] = 1'b1; req_level[0] = 2'd2; req_id[0] = 2'd2;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("s4_hold", 32'({resp_valid[0], req_ready[0], rf_check}), 32'h8);
            chk("s4_pay", 32'({resp_err[0], resp_level[0], resp_id[0]}), 32'h0c);
        end
        resp_ready[0] = 1'b1; req_valid[0] = 1'b0;
        @(posedge clk); #1;
        resp_ready[0] = 1'b0;
        chk("s4_nochk", 32'(n_chk[0] + n_chk[1]), 32'(ns));
        @(negedge clk);
        chk("s4_idle", 32'({resp_valid[0], req_ready[0]}), 32'h1);

        // 5: async reset with port0 in RESP and port1 in CHECK
        @(posedge clk); #1;
        send(1, 2'd0, 2'd2);
        @(posedge clk); #1;
        send(0, 2'd0, 2'd2);
        @(posedge clk); #1;
        send(1, 2'd1, 2'd1);
        @(negedge clk);
        chk("s5_pre", 32'({resp_valid[0], rf_check[1]}), 32'h3);
        #1 rst_n = 1'b0;
        #1 chk("s5_async", 32'({resp_valid, rf_check}), 32'h0);
        @(posedge clk); #1;
        chk("s5_in_rst", 32'({resp_valid, req_ready}), 32'h3);
        @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("s5_rdy", 32'({resp_valid, req_ready}), 32'h3);

        // 6: random streams, 10k requests
        acc[0] = 0; acc[1] = 0; issued = 0; cyc = 0;
        s0 = n_chk[0]; s1 = n_chk[1]; sd = n_done; se = n_err; sp = pairs;
        while ((issued < 10000 || req_valid != 2'b00) && cyc < 40000) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            @(posedge clk); #1;
            cyc++;
            for (int p = 0; p < 2; p++) begin
                if (hs[p]) begin
                    acc[p]++;
                    req_valid[p] = 1'b0;
                end
                if (!req_valid[p] && issued < 10000 && $urandom_range(0, 3) != 0) begin
                    req_valid[p] = 1'b1;
                    req_level[p] = 2'($urandom);
                    req_id[p]    = 2'($urandom);
                    issued++;
                end
            end
            resp_ready = 2'($urandom);
        end
        chk("s6_timeout", 32'(cyc < 40000), 32'h1);
        resp_ready = 2'b11;
        repeat (4) @(posedge clk);
        #1;
        chk("s6_acc", 32'(acc[0] + acc[1]), 32'd10000);
        chk("s6_chk0", 32'(n_chk[0] - s0), 32'(acc[0]));
        chk("s6_chk1", 32'(n_chk[1] - s1), 32'(acc[1]));
        chk("s6_done", 32'(n_done - sd), 32'(pairs - sp));
        chk("s6_some", 32'((n_done - sd) > 100), 32'h1);
        chk("s6_err", 32'(n_err - se), 32'h0);
        chk("s6_idle", 32'({resp_valid, req_ready}), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
